if_fetch_ctrl: RTL and testbench
================================

Name: if_fetch_ctrl

Overview:
- Instruction-fetch sequencer in front of the PC: selects the next fetch address (reset vector, exception vector, ERET return, branch target, sequential PC+4).
- Drives the SRAM-like instruction bus (req / addr_ok / data_ok) with at most one outstanding request.
- Presents fetched instructions to decode via a valid/ready handshake.
- Squashes stale in-flight fetches on redirect.

Parameters:
- RESET_PC, 32'hbfc00000, PC loaded on reset
- EXC_PC, 32'hbfc00380, exception entry vector

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- exception  in  1  redirect pulse to EXC_PC
- eret  in  1  redirect pulse to epc
- epc  in  32  ERET return address
- br_take  in  1  branch redirect pulse
- br_target  in  32  branch target
- inst_req  out  1  bus request
- inst_addr  out  32  bus address
- inst_addr_ok  in  1  request accepted
- inst_data_ok  in  1  read data returned
- inst_rdata  in  32  read data
- if_valid  out  1  instruction available to decode
- if_ready  in  1  decode accepts
- if_pc  out  32  PC of delivered instruction
- if_inst  out  32  delivered instruction
- if_adel  out  1  delivered slot is an address-error (PC[1:0]!=0)

Behaviour:
- Reset is synchronous and active-high; clock is clk.
- Reset state:
  - state=S_REQ; req_pc=RESET_PC; next_pc=RESET_PC; discard=0
  - inst_req=0 during the reset cycle
  - if_valid=0, if_adel=0, if_pc=0, if_inst=0
- Redirect target, one priority mux: exception ? EXC_PC : eret ? epc : br_take ? br_target. "redir" is the OR of the three inputs.
- inst_addr = req_pc at all times. req_pc must not change while inst_req=1 and addr_ok=0.
- S_REQ:
  - inst_req = 1 when req_pc[1:0]==0, and not in the reset cycle.
  - addr_ok=1 → S_WAIT; next_pc <= req_pc+4 (wraps mod 2^32).
  - Unaligned req_pc: inst_req=0 → S_HOLD with if_valid=1, if_adel=1, if_inst=0, if_pc=req_pc.
  - redir: next_pc <= target. discard <= 1 if the request is already driven (aligned), because the bus will still accept it.
  - Unaligned case with redir: req_pc <= target and stay in S_REQ.
- S_WAIT:
  - data_ok with discard=0 → capture if_inst=inst_rdata, if_pc=req_pc, if_valid=1 → S_HOLD.
  - data_ok with discard=1 → discard<=0, req_pc<=next_pc → S_REQ.
  - redir without data_ok → discard<=1, next_pc<=target.
  - redir with data_ok in the same cycle → data dropped, req_pc<=target → S_REQ.
- S_HOLD:
  - if_valid held stable until if_ready.
  - if_ready → if_valid<=0, if_adel<=0, req_pc<=next_pc → S_REQ.
  - redir → if_valid<=0, req_pc<=target → S_REQ. Redirect overrides if_ready in the same cycle.
- Latency, zero-wait bus: addr_ok in the issue cycle, data_ok the next cycle.
  - Request cycle N, instruction valid in cycle N+2.
  - With if_ready held high, one instruction per 3 cycles.
- Repeated redirects while discard=1: the latest target wins; discard stays 1, so only one response is dropped.
- Delay-slot ordering belongs to decode: br_take is pulsed only after the delay-slot instruction has been accepted.
- Reset mid-transaction:
  - Any outstanding bus response is not tracked.
  - The bus is reset by the same signal, so no late data_ok arrives.

Decomposition:
- Shared package holds:
  - the state enum (S_REQ, S_WAIT, S_HOLD)
  - EXC_PC and RESET_PC vector constants, also used by CP0 and pc
- Optional sub-module fetch_redirect_mux: the combinational priority selector producing redir and target.
- All sequential logic stays in the top.

Test Plan:
- Reset, then a zero-wait bus with if_ready=1 → inst_addr sequence 0xbfc00000, 0xbfc00004, 0xbfc00008. if_pc matches each, and each comes 2 cycles after its request.
- br_take=1, br_target=0xbfc00100 while in S_WAIT, data_ok returns the next cycle → that instruction is dropped (if_valid stays 0). The next inst_addr is 0xbfc00100.
- exception and br_take in the same cycle, in S_HOLD → if_valid drops; next inst_addr=0xbfc00380.
- eret, epc=0x80000002 → no inst_req; next cycle if_valid=1, if_adel=1, if_pc=0x80000002, if_inst=0.
- addr_ok held low for 3 cycles with br_take in cycle 2 → inst_addr stays unchanged until accepted. The response is discarded, then br_target is fetched.
- if_ready held low for 5 cycles in S_HOLD → if_valid, if_pc and if_inst stable, inst_req=0. After if_ready, inst_addr = if_pc+4.

Source files
------------

// File: rtl/if_fetch_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// if_fetch_ctrl_pkg
// Shared definitions for the instruction-fetch sequencer: the fetch FSM state
// type, the reset and exception vectors (also used by CP0 and the PC logic),
// and a small alignment helper.
// ----------------------------------------------------------------------------
package if_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC = 32'hbfc00000;
  localparam logic [31:0] EXC_PC   = 32'hbfc00380;

  // A fetch address is legal only when word aligned.
  function automatic logic pc_aligned(input logic [1:0] pc_low);
    return (pc_low == 2'b00);
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// ----------------------------------------------------------------------------
// if_fetch_ctrl_if
// Bundles the SRAM-like instruction bus (req / addr_ok / data_ok) and the
// fetch-to-decode valid/ready handshake.
//   master : the fetch controller (drives req/addr and the decode slot)
//   slave  : the instruction memory plus decode stage
// ----------------------------------------------------------------------------
interface if_fetch_ctrl_if;

  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;

  modport master (
    output inst_req, inst_addr, if_valid, if_pc, if_inst, if_adel,
    input  inst_addr_ok, inst_data_ok, inst_rdata, if_ready
  );

  modport slave (
    input  inst_req, inst_addr, if_valid, if_pc, if_inst, if_adel,
    output inst_addr_ok, inst_data_ok, inst_rdata, if_ready
  );

endinterface

// File: rtl/if_fetch_ctrl_fetch_redirect_mux.sv
// ----------------------------------------------------------------------------
// fetch_redirect_mux
// Combinational priority selector for fetch redirects.
//   exception/eret/br_take : redirect requests (exception highest priority)
//   epc, br_target         : candidate targets
//   redir                  : any redirect this cycle
//   target                 : selected redirect address
// ----------------------------------------------------------------------------
module fetch_redirect_mux
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_PC = if_fetch_ctrl_pkg::EXC_PC
) (
  input  logic        exception,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        br_take,
  input  logic [31:0] br_target,
  output logic        redir,
  output logic [31:0] target
);

  assign redir  = exception | eret | br_take;
  assign target = exception ? EXC_PC :
                  eret      ? epc    :
                  br_take   ? br_target : 32'h0;

endmodule

// File: rtl/if_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// if_fetch_ctrl
// Instruction-fetch sequencer. Chooses the next fetch address, issues at most
// one outstanding request on the instruction bus, and hands each fetched
// instruction to decode through a valid/ready slot. Responses belonging to a
// fetch that was overtaken by a redirect are dropped.
//   clk, reset            : clock, synchronous active-high reset
//   exception, eret, epc  : redirect to EXC_PC / to epc
//   br_take, br_target    : branch redirect
//   bus (master)          : instruction bus + decode slot
// ----------------------------------------------------------------------------
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = if_fetch_ctrl_pkg::RESET_PC,
  parameter logic [31:0] EXC_PC   = if_fetch_ctrl_pkg::EXC_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exception,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        br_take,
  input  logic [31:0] br_target,
  if_fetch_ctrl_if.master bus
);

  fetch_state_e state;
  logic [31:0]  req_pc;
  logic [31:0]  next_pc;
  logic         discard;
  logic         if_valid_q;
  logic         if_adel_q;
  logic [31:0]  if_pc_q;
  logic [31:0]  if_inst_q;

  logic         redir;
  logic [31:0]  target;
  logic         aligned;

  fetch_redirect_mux #(
    .EXC_PC(EXC_PC)
  ) u_redirect_mux (
    .exception(exception),
    .eret     (eret),
    .epc      (epc),
    .br_take  (br_take),
    .br_target(br_target),
    .redir    (redir),
    .target   (target)
  );

  assign aligned = pc_aligned(req_pc[1:0]);

  // The request is only driven for aligned addresses; an unaligned PC is
  // turned into an address-error slot instead of a bus access.
  assign bus.inst_req  = !reset && (state == S_REQ) && aligned;
  assign bus.inst_addr = req_pc;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_adel   = if_adel_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_inst   = if_inst_q;

  // Fetch FSM. req_pc only moves when no request is pending on the bus; a
  // redirect that arrives while a request is in flight is parked in next_pc
  // and the stale response is dropped via discard.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_REQ;
      req_pc     <= RESET_PC;
      next_pc    <= RESET_PC;
      discard    <= 1'b0;
      if_valid_q <= 1'b0;
      if_adel_q  <= 1'b0;
      if_pc_q    <= 32'h0;
      if_inst_q  <= 32'h0;
    end else begin
      case (state)
        S_REQ: begin
          if (aligned) begin
            if (bus.inst_addr_ok) begin
              state <= S_WAIT;
              if (redir) begin
                next_pc <= target;
                discard <= 1'b1;
              end else if (!discard) begin
                next_pc <= req_pc + 32'd4;
              end
            end else if (redir) begin
              // The bus will still accept this request, so its data is junk.
              next_pc <= target;
              discard <= 1'b1;
            end
          end else if (redir) begin
            req_pc  <= target;
            next_pc <= target;
          end else begin
            state      <= S_HOLD;
            next_pc    <= req_pc + 32'd4;
            if_valid_q <= 1'b1;
            if_adel_q  <= 1'b1;
            if_pc_q    <= req_pc;
            if_inst_q  <= 32'h0;
          end
        end

        S_WAIT: begin
          if (bus.inst_data_ok) begin
            if (redir) begin
              state   <= S_REQ;
              req_pc  <= target;
              next_pc <= target;
              discard <= 1'b0;
            end else if (discard) begin
              state   <= S_REQ;
              req_pc  <= next_pc;
              discard <= 1'b0;
            end else begin
              state      <= S_HOLD;
              if_valid_q <= 1'b1;
              if_adel_q  <= 1'b0;
              if_pc_q    <= req_pc;
              if_inst_q  <= bus.inst_rdata;
            end
          end else if (redir) begin
            next_pc <= target;
            discard <= 1'b1;
          end
        end

        S_HOLD: begin
          // A redirect wins over a same-cycle accept by decode.
          if (redir) begin
            state      <= S_REQ;
            req_pc     <= target;
            next_pc    <= target;
            if_valid_q <= 1'b0;
            if_adel_q  <= 1'b0;
          end else if (bus.if_ready) begin
            state      <= S_REQ;
            req_pc     <= next_pc;
            if_valid_q <= 1'b0;
            if_adel_q  <= 1'b0;
          end
        end

        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_ctrl
// Directed bench for if_fetch_ctrl. A small bus model answers requests with a
// data word derived from the address; expected deliveries are queued when a
// fetch is issued and compared when decode accepts the slot.
// ----------------------------------------------------------------------------
module tb_if_fetch_ctrl;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
    int          reqCycle;
    bit          chkLat;
  } expEntry_t;

  logic        clk;
  logic        reset;
  logic        exception;
  logic        eret;
  logic [31:0] epc;
  logic        br_take;
  logic [31:0] br_target;

  logic        addrStall;
  logic        dataStall;
  logic        pending;
  logic [31:0] pendAddr;
  bit          prevValid;
  int          cycle;
  int          checks;
  int          errors;
  expEntry_t   sbQueue[$];

  if_fetch_ctrl_if bus ();

  if_fetch_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .exception(exception),
    .eret     (eret),
    .epc      (epc),
    .br_take  (br_take),
    .br_target(br_target),
    .bus      (bus)
  );

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return addr ^ 32'h5a5a0f0f;
  endfunction

  // Clock and cycle counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  // Zero-wait instruction memory with optional stalls on either phase.
  assign bus.inst_addr_ok = bus.inst_req && !addrStall;
  assign bus.inst_data_ok = pending && !dataStall;
  assign bus.inst_rdata   = pending ? memWord(pendAddr) : 32'h0;

  always @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
    end else begin
      if (bus.inst_data_ok) pending <= 1'b0;
      if (bus.inst_req && bus.inst_addr_ok) begin
        pending  <= 1'b1;
        pendAddr <= bus.inst_addr;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic exc, input logic er, input logic [31:0] ep,
                               input logic bt, input logic [31:0] btgt);
    exception = exc;
    eret      = er;
    epc       = ep;
    br_take   = bt;
    br_target = btgt;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for an accepted request, checks its address and
  // optionally queues the delivery decode should later see.
  task automatic waitAccept(input logic [31:0] expAddr, input bit pushExp);
    bit found;
    expEntry_t e;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (bus.inst_req && bus.inst_addr_ok) found = 1'b1;
    end
    checkOutput("accept_seen", 32'(found), 32'd1);
    if (found) begin
      checkOutput("inst_addr", bus.inst_addr, expAddr);
      if (pushExp) begin
        e.pc       = expAddr;
        e.inst     = memWord(expAddr);
        e.adel     = 1'b0;
        e.reqCycle = cycle;
        e.chkLat   = 1'b1;
        sbQueue.push_back(e);
      end
    end
  endtask

  // Scoreboard monitor: checks request-to-valid latency and compares every
  // accepted decode slot against the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.if_valid && !prevValid && sbQueue.size() > 0 && sbQueue[0].chkLat)
        checkOutput("latency", 32'(cycle - sbQueue[0].reqCycle), 32'd2);
      if (bus.if_valid && bus.if_ready && !(exception || eret || br_take)) begin
        checkOutput("sb_nonempty", 32'(sbQueue.size() != 0), 32'd1);
        if (sbQueue.size() != 0) begin
          expEntry_t e;
          e = sbQueue.pop_front();
          checkOutput("if_pc", bus.if_pc, e.pc);
          checkOutput("if_inst", bus.if_inst, e.inst);
          checkOutput("if_adel", 32'(bus.if_adel), 32'(e.adel));
        end
      end
    end
    prevValid = bus.if_valid;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence.
  initial begin
    cycle        = 0;
    checks       = 0;
    errors       = 0;
    prevValid    = 1'b0;
    reset        = 1'b1;
    addrStall    = 1'b0;
    dataStall    = 1'b0;
    bus.if_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Reset state.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_inst_req", 32'(bus.inst_req), 32'd0);
    checkOutput("rst_if_valid", 32'(bus.if_valid), 32'd0);
    checkOutput("rst_if_adel", 32'(bus.if_adel), 32'd0);
    checkOutput("rst_if_pc", bus.if_pc, 32'h0);
    checkOutput("rst_if_inst", bus.if_inst, 32'h0);
    checkOutput("rst_inst_addr", bus.inst_addr, 32'hbfc00000);
    nextCycle();
    reset        = 1'b0;
    bus.if_ready = 1'b1;

    // Sequential fetch on a zero-wait bus.
    waitAccept(32'hbfc00000, 1'b1);
    waitAccept(32'hbfc00004, 1'b1);
    waitAccept(32'hbfc00008, 1'b1);

    // Branch while waiting for data: the response is dropped.
    waitAccept(32'hbfc0000c, 1'b0);
    nextCycle();
    dataStall = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'hbfc00100);
    @(negedge clk);
    checkOutput("br_wait_valid", 32'(bus.if_valid), 32'd0);
    nextCycle();
    dataStall = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("br_drop_valid", 32'(bus.if_valid), 32'd0);
    waitAccept(32'hbfc00100, 1'b0);

    // Exception and branch together while holding a slot.
    bus.if_ready = 1'b0;
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("hold_valid", 32'(bus.if_valid), 32'd1);
    checkOutput("hold_pc", bus.if_pc, 32'hbfc00100);
    checkOutput("hold_inst", bus.if_inst, memWord(32'hbfc00100));
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'hbfc00200);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    waitAccept(32'hbfc00380, 1'b1);
    checkOutput("exc_valid_drop", 32'(bus.if_valid), 32'd0);
    bus.if_ready = 1'b1;

    // ERET to an unaligned address, arriving together with data_ok.
    waitAccept(32'hbfc00384, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'h80000002, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("adel_no_req", 32'(bus.inst_req), 32'd0);
    checkOutput("adel_addr", bus.inst_addr, 32'h80000002);
    checkOutput("adel_pre_valid", 32'(bus.if_valid), 32'd0);
    bus.if_ready = 1'b0;
    @(negedge clk);
    checkOutput("adel_valid", 32'(bus.if_valid), 32'd1);
    checkOutput("adel_flag", 32'(bus.if_adel), 32'd1);
    checkOutput("adel_pc", bus.if_pc, 32'h80000002);
    checkOutput("adel_inst", bus.if_inst, 32'h0);

    // Stalled address phase with a branch in its second cycle.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h80001000);
    addrStall = 1'b1;
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("stall1_req", 32'(bus.inst_req), 32'd1);
    checkOutput("stall1_addr", bus.inst_addr, 32'h80001000);
    checkOutput("stall1_adel", 32'(bus.if_adel), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h80002000);
    @(negedge clk);
    checkOutput("stall2_addr", bus.inst_addr, 32'h80001000);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("stall3_addr", bus.inst_addr, 32'h80001000);
    nextCycle();
    addrStall = 1'b0;
    waitAccept(32'h80001000, 1'b0);
    waitAccept(32'h80002000, 1'b1);

    // Decode back-pressure: the slot must stay stable.
    nextCycle();
    nextCycle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_valid", 32'(bus.if_valid), 32'd1);
      checkOutput("bp_pc", bus.if_pc, 32'h80002000);
      checkOutput("bp_inst", bus.if_inst, memWord(32'h80002000));
      checkOutput("bp_no_req", 32'(bus.inst_req), 32'd0);
      nextCycle();
    end
    bus.if_ready = 1'b1;
    waitAccept(32'h80002004, 1'b1);

    repeat (4) nextCycle();
    checkOutput("sb_drained", 32'(sbQueue.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
